// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the delay scheduler: FSM state encoding and
// the round-robin pointer advance.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dsch_state_t;

  // Pointer advance with wrap; nreq is passed in so the package stays parameter-free.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/delay_sched_rr_pick.sv
// Rotating-priority picker: returns the first asserted request at or after
// ptr_i, wrapping modulo NREQ.
module delay_sched_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   sel_o,
  output logic            vld_o
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [PW:0] idx;

  always_comb begin
    sel_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_i} + (PW+1)'(i);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!vld_o && req_i[idx[PW-1:0]]) begin
        sel_o = idx[PW-1:0];
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_sched.sv
// Shares one down-counting delay timer between NREQ requesters using a
// rotating-priority grant; pulses done for the owner when the count expires.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic                     ena,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0][DW-1:0]  dly,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [DW-1:0]            cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  dsch_state_t     state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [DW-1:0]   cnt_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   sel_q;

  logic [PW-1:0]   pick;
  logic            pick_vld;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] sel_oh;
  logic [PW-1:0]   ptr_d;

  delay_sched_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .sel_o (pick),
    .vld_o (pick_vld)
  );

  assign pick_oh = NREQ'(1) << pick;
  assign sel_oh  = NREQ'(1) << sel_q;
  assign ptr_d   = PW'(rr_next(32'(sel_q), NREQ));

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          gnt_q  <= '0;
          done_q <= '0;
          if (pick_vld) begin
            sel_q <= pick;
            gnt_q <= pick_oh;
            cnt_q <= dly[pick];
            // A zero delay completes in the grant cycle itself.
            if (dly[pick] == '0) begin
              done_q  <= pick_oh;
              state_q <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (!req[sel_q]) begin
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else if (ena && cnt_q != '0) begin
            cnt_q <= cnt_q - DW'(1);
            if (cnt_q == DW'(1)) begin
              done_q  <= sel_oh;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          gnt_q   <= '0;
          done_q  <= '0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          done_q  <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign cnt  = cnt_q;
  assign busy = (state_q != IDLE);

endmodule
